// File: rtl/irq_arbiter_if.sv
// Word register port between software and the interrupt arbiter.
interface irq_arbiter_if;
  logic        reg_we_i;
  logic [31:0] reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;

  modport master (
    output reg_we_i,
    output reg_addr_i,
    output reg_wdata_i,
    input  reg_rdata_o
  );

  modport slave (
    input  reg_we_i,
    input  reg_addr_i,
    input  reg_wdata_i,
    output reg_rdata_o
  );
endinterface

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: synchronises, latches (edge/level), masks and selects the
// lowest-numbered enabled pending source for the core exception unit.
module irq_arbiter #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  irq_arbiter_if.slave       bus,
  output logic               int_req_o,
  output logic [7:0]         int_id_o
);

  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync;
  logic [NUM_IRQ-1:0] r_sync_prev;
  logic [NUM_IRQ-1:0] r_ie;
  logic [NUM_IRQ-1:0] r_type;
  logic [NUM_IRQ-1:0] r_pending;
  logic               r_int_req;
  logic [7:0]         r_int_id;
  logic [31:0]        r_rdata;

  logic [1:0]         w_sel;
  logic               w_wr_ie;
  logic               w_wr_type;
  logic               w_wr_pend;
  logic               w_wr_claim;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_pending_nxt;
  logic [NUM_IRQ-1:0] w_active;
  logic               w_any;
  logic [7:0]         w_id;
  logic [31:0]        w_rdata;
  logic               w_unused_addr;

  assign w_sel         = bus.reg_addr_i[3:2];
  assign w_unused_addr = ^{bus.reg_addr_i[31:4], bus.reg_addr_i[1:0]};
  assign w_wr_ie       = bus.reg_we_i & (w_sel == 2'd0);
  assign w_wr_type     = bus.reg_we_i & (w_sel == 2'd1);
  assign w_wr_pend     = bus.reg_we_i & (w_sel == 2'd2);
  assign w_wr_claim    = bus.reg_we_i & (w_sel == 2'd3);

  // Pending next-state; clears only touch edge-type bits and a new edge wins.
  always_comb begin
    w_rise        = r_sync & ~r_sync_prev;
    w_clr         = '0;
    w_pending_nxt = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_clr[i] = r_type[i] & ((w_wr_pend & bus.reg_wdata_i[i]) |
                              (w_wr_claim & (bus.reg_wdata_i == 32'(i))));
      if (r_type[i]) begin
        w_pending_nxt[i] = w_rise[i] | (r_pending[i] & ~w_clr[i]);
      end else begin
        w_pending_nxt[i] = r_sync[i];
      end
    end
  end

  // Priority select: scan downwards so the lowest active index is kept last.
  always_comb begin
    w_active = r_pending & r_ie;
    w_any    = |w_active;
    w_id     = 8'h00;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      w_id = w_active[i] ? 8'(i) : w_id;
    end
  end

  // Read mux on pre-write register contents.
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (w_sel)
      2'd0:    w_rdata = 32'(r_ie);
      2'd1:    w_rdata = 32'(r_type);
      2'd2:    w_rdata = 32'(r_pending);
      2'd3:    w_rdata = r_int_req ? {24'h00_0000, r_int_id} : 32'hFFFF_FFFF;
      default: w_rdata = 32'h0000_0000;
    endcase
  end

  // Two-flop synchroniser plus previous-sample flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= '0;
      r_sync      <= '0;
      r_sync_prev <= '0;
    end else begin
      r_sync1     <= irq_src_i;
      r_sync      <= r_sync1;
      r_sync_prev <= r_sync;
    end
  end

  // Software configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ie   <= '0;
      r_type <= '0;
    end else begin
      if (w_wr_ie) begin
        r_ie <= bus.reg_wdata_i[NUM_IRQ-1:0];
      end
      if (w_wr_type) begin
        r_type <= bus.reg_wdata_i[NUM_IRQ-1:0];
      end
    end
  end

  // Pending vector, registered request/ID and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_int_req <= 1'b0;
      r_int_id  <= 8'h00;
      r_rdata   <= 32'h0000_0000;
    end else begin
      r_pending <= w_pending_nxt;
      r_int_req <= w_any;
      r_int_id  <= w_id;
      r_rdata   <= w_rdata;
    end
  end

  assign int_req_o       = r_int_req;
  assign int_id_o        = r_int_id;
  assign bus.reg_rdata_o = r_rdata;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: stimulus queues expectations per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_irq_arbiter;

  localparam int NUM_IRQ = 8;

  typedef struct {
    int          cyc;
    string       name;
    bit          chk_out;
    bit          chk_rd;
    logic        exp_req;
    logic [7:0]  exp_id;
    logic [31:0] exp_rd;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq_src;
  logic               int_req;
  logic [7:0]         int_id;

  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  bit   tb_done = 1'b0;
  exp_t q[$];

  irq_arbiter_if bus_if ();

  irq_arbiter #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src_i (irq_src),
    .bus       (bus_if),
    .int_req_o (int_req),
    .int_id_o  (int_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(exp_t e);
    int idx;
    idx = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc > e.cyc) begin
        idx = i;
        break;
      end
    end
    q.insert(idx, e);
  endfunction

  function automatic void exp_out(int at, string nm, logic req, logic [7:0] id);
    exp_t e;
    e.cyc = at; e.name = nm; e.chk_out = 1'b1; e.chk_rd = 1'b0;
    e.exp_req = req; e.exp_id = id; e.exp_rd = 32'h0;
    push(e);
  endfunction

  function automatic void exp_rd(int at, string nm, logic [31:0] val);
    exp_t e;
    e.cyc = at; e.name = nm; e.chk_out = 1'b0; e.chk_rd = 1'b1;
    e.exp_req = 1'b0; e.exp_id = 8'h0; e.exp_rd = val;
    push(e);
  endfunction

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [31:0] addr, logic [31:0] data);
    bus_if.reg_we_i    = 1'b1;
    bus_if.reg_addr_i  = addr;
    bus_if.reg_wdata_i = data;
    tick();
    bus_if.reg_we_i    = 1'b0;
    bus_if.reg_wdata_i = 32'h0;
  endtask

  task automatic rd(logic [31:0] addr, logic [31:0] expv, string nm);
    bus_if.reg_we_i   = 1'b0;
    bus_if.reg_addr_i = addr;
    exp_rd(cyc + 1, nm, expv);
    tick();
  endtask

  // Monitor: compare every expectation due at this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation for cycle %0d reached at cycle %0d", e.name, e.cyc, cyc);
        end else begin
          if (e.chk_out) begin
            checks++;
            if (int_req !== e.exp_req) begin
              errors++;
              $display("FAIL %s: cyc %0d int_req_o got %0b expected %0b", e.name, cyc, int_req, e.exp_req);
            end
            checks++;
            if (int_id !== e.exp_id) begin
              errors++;
              $display("FAIL %s: cyc %0d int_id_o got %0d expected %0d", e.name, cyc, int_id, e.exp_id);
            end
          end
          if (e.chk_rd) begin
            checks++;
            if (bus_if.reg_rdata_o !== e.exp_rd) begin
              errors++;
              $display("FAIL %s: cyc %0d reg_rdata_o got %h expected %h", e.name, cyc, bus_if.reg_rdata_o, e.exp_rd);
            end
          end
        end
      end
      if (tb_done) begin
        checks++;
        if (q.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d expectations never checked", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: summary not reached");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int k;
    rst_n              = 1'b0;
    irq_src            = 8'hFF;
    bus_if.reg_we_i    = 1'b0;
    bus_if.reg_addr_i  = 32'h0;
    bus_if.reg_wdata_i = 32'h0;

    // Reset held with all sources high
    exp_out(1, "rst_out1", 1'b0, 8'd0);
    exp_out(2, "rst_out2", 1'b0, 8'd0);
    exp_rd(1, "rst_rd1", 32'h0);
    exp_rd(2, "rst_rd2", 32'h0);
    tick(2);

    // Release together with IE=0xFF; request appears 4 edges later
    rst_n = 1'b1;
    k = cyc;
    exp_out(k + 1, "rel_e1", 1'b0, 8'd0);
    exp_out(k + 2, "rel_e2", 1'b0, 8'd0);
    exp_out(k + 3, "rel_e3", 1'b0, 8'd0);
    exp_out(k + 4, "rel_e4", 1'b1, 8'd0);
    exp_rd(k + 1, "ie_prewrite_rd", 32'h0);
    wr(32'h0, 32'hFF);
    tick(3);

    // Level deassertion
    irq_src = 8'h00;
    k = cyc;
    exp_out(k + 3, "lvl_drop_e3", 1'b1, 8'd0);
    exp_out(k + 4, "lvl_drop_e4", 1'b0, 8'd0);
    tick(5);
    rd(32'h0, 32'h0000_00FF, "ie_rd");

    // Priority: 5 and 3 together, then drop 3
    irq_src = 8'h28;
    k = cyc;
    exp_out(k + 3, "prio_e3", 1'b0, 8'd0);
    exp_out(k + 4, "prio_e4", 1'b1, 8'd3);
    tick(5);
    rd(32'hC, 32'h0000_0003, "claim_rd3");
    irq_src = 8'h20;
    k = cyc;
    exp_out(k + 2, "drop3_e2", 1'b1, 8'd3);
    exp_out(k + 4, "drop3_e4", 1'b1, 8'd5);
    tick(5);
    irq_src = 8'h00;
    tick(5);

    // Edge latch and claim on source 0
    wr(32'h4, 32'h01);
    wr(32'h0, 32'h01);
    irq_src = 8'h01;
    k = cyc;
    exp_out(k + 3, "edge_e3", 1'b0, 8'd0);
    exp_out(k + 4, "edge_e4", 1'b1, 8'd0);
    exp_out(k + 8, "edge_held", 1'b1, 8'd0);
    tick(3);
    irq_src = 8'h00;
    tick(5);
    rd(32'hC, 32'h0000_0000, "claim_rd0");
    exp_out(cyc + 2, "claim_oor", 1'b1, 8'd0);
    wr(32'hC, 32'd8);
    exp_out(cyc + 1, "claim_n", 1'b1, 8'd0);
    exp_out(cyc + 2, "claim_n1", 1'b0, 8'd0);
    wr(32'hC, 32'd0);
    rd(32'h8, 32'h0, "pend_after_claim");
    rd(32'hC, 32'hFFFF_FFFF, "claim_empty");

    // Set/clear collision on edge source 2
    wr(32'h4, 32'h05);
    wr(32'h0, 32'h04);
    irq_src = 8'h04;
    k = cyc;
    exp_out(k + 4, "coll_e4", 1'b1, 8'd2);
    exp_out(k + 6, "coll_e6", 1'b1, 8'd2);
    tick(2);
    wr(32'h8, 32'h04);
    tick(2);
    rd(32'h8, 32'h0000_0004, "coll_pend_rd");
    exp_out(cyc + 2, "w1c_clear", 1'b0, 8'd0);
    wr(32'h8, 32'h04);
    rd(32'h8, 32'h0, "w1c_pend_rd");
    irq_src = 8'h00;
    tick(4);

    // Mask with level source 1; high IE bits ignored
    wr(32'h4, 32'h0);
    wr(32'h0, 32'hFFFF_FF00);
    rd(32'h0, 32'h0, "ie_high_bits");
    irq_src = 8'h02;
    tick(5);
    exp_out(cyc + 1, "mask_off", 1'b0, 8'd0);
    rd(32'hC, 32'hFFFF_FFFF, "mask_claim");
    rd(32'h8, 32'h0000_0002, "mask_pend");
    wr(32'h8, 32'h02);
    rd(32'h8, 32'h0000_0002, "lvl_w1c_ignored");
    exp_out(cyc + 1, "ie_wr_n", 1'b0, 8'd0);
    exp_out(cyc + 2, "ie_wr_n1", 1'b1, 8'd1);
    wr(32'h0, 32'h02);
    tick(2);

    // Reset mid-operation with source 1 still high
    rst_n = 1'b0;
    exp_out(cyc, "midrst_out", 1'b0, 8'd0);
    exp_rd(cyc, "midrst_rd", 32'h0);
    tick();
    rst_n = 1'b1;
    rd(32'h0, 32'h0, "midrst_ie");
    tick(2);
    exp_out(cyc + 1, "reen_n", 1'b0, 8'd0);
    exp_out(cyc + 2, "reen_n1", 1'b1, 8'd1);
    wr(32'h0, 32'h02);
    tick(2);

    tb_done = 1'b1;
  end

endmodule
